cache_set_sequencer: RTL
========================

// Module: cache_set_sequencer
// PURPOSE
// - Upstream feeder of the processor stage: owns the L1 tag/state arrays (8-way data, 4-way instr), accepts one
//   trace command at a time, reads the addressed set, presents it to processor, captures its return lines and
//   writes them back. Also executes n=8 (clear all) as a set sweep and n=9 (print) as a one-cycle request.
// PARAMETERS
// - SETS        16384  sets per cache; power of two; index = command_t.address.set_index
// - DATA_WAYS   8      data-cache ways (fixed by processor port shape)
// - INSTR_WAYS  4      instr-cache ways (fixed by processor port shape)
// PORTS
// - clk            in   1                     single clock, all state on posedge
// - rst            in   1                     synchronous, active-high reset
// - cmd_valid      in   1                     trace command offered
// - cmd            in   command_t             trace command {n, address}
// - cmd_ready      out  1                     sequencer can accept; cmd taken when cmd_valid & cmd_ready
// - instruction    out  command_t             registered command to processor
// - read_enable    out  1                     high exactly in PRESENT
// - current_line_d out  cache_line_t [8]      data set to processor
// - current_line_i out  cache_line_t [4]      instr set to processor
// - return_line_d  in   cache_line_t [8]      updated data set from processor
// - return_line_i  in   cache_line_t [4]      updated instr set from processor
// - retire         out  1                     one-cycle pulse when a command completes
// - print_req      out  1                     one-cycle pulse for n=9
// - bad_cmd        out  1                     one-cycle pulse for unsupported n (command dropped)
// - retired_count  out  32                    commands retired since reset, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
// - States: SWEEP, IDLE, FETCH, PRESENT, CAPTURE, WRITE. cmd_ready = (state==IDLE).
// - Reset (rst high at posedge): state<=SWEEP, sweep_idx<=0, all outputs 0 (instruction, lines = '0,
//   read_enable/retire/print_req/bad_cmd=0, retired_count=0). Applies mid-operation; in-flight cmd discarded, no write.
// - SWEEP: each cycle writes set sweep_idx of both arrays to tag=0, MESI_bits=0 (I), LRU=way index; sweep_idx++.
//   At sweep_idx==SETS-1 write that set and go IDLE next cycle. Takes exactly SETS cycles; no retire for rst sweep.
// - IDLE, accept with n in {0,1,2,3,4}: latch cmd into instruction -> FETCH.
//   n=8: latch, go SWEEP; retire pulses in the cycle leaving SWEEP. n=9: print_req=1 and retire=1 next cycle,
//   stay IDLE (cmd_ready drops for that one cycle). Other n: bad_cmd=1 next cycle, stay IDLE, no retire.
// - FETCH: read both arrays at instruction.address.set_index into current_line_d/i (registered).
// - PRESENT: read_enable=1; lines and instruction held stable.
// - CAPTURE: register return_line_d/i (processor is combinational; one full cycle of settle).
// - WRITE: n in {0,1,3,4} writes captured data set only; n=2 writes captured instr set only; retire=1;
//   retired_count++ (saturating); -> IDLE.
// - Latency accept->retire: 4 cycles (FETCH,PRESENT,CAPTURE,WRITE); next accept earliest 5 cycles after previous.
// - Back-to-back same set: WRITE completes before next FETCH, so second command sees updated set (no bypass needed).
// - current_line_*/instruction hold last values outside FETCH; processor repeat detection is unaffected.
// - set_index width = $clog2(SETS); addresses beyond are impossible by construction.
// STRUCTURE
// - my_struct_package gains: state enum seq_state_t, localparams CMD_CLEAR=8, CMD_PRINT=9, DATA_WAYS, INSTR_WAYS.
//   command_t / cache_line_t used unchanged.
// - One sub-module: cache_set_array #(SETS, WAYS) - 1 sync write port, registered read port; instantiated x2.
// TESTING (SETS=16 for sim)
// - Reset: rst 1 cycle -> cmd_ready low 16 cycles, then high; every set reads MESI=0, LRU=way, tag=0.
// - Read miss n=0, set 3, tag 0x2A: read_enable high exactly cycle 2 after accept; retire at cycle 4;
//   refetch set 3 shows the processor-returned line with tag 0x2A, LRU 0.
// - n=2 to set 5: only instr array set 5 changes; data set 5 bit-identical before/after.
// - Two back-to-back n=1 to same set/tag: second FETCH shows first's write; retired_count = 2.
// - n=8 after traffic: 16-cycle sweep, single retire at end, all sets reinitialised; n=9 -> print_req 1 cycle,
//   retire same cycle; n=6 -> bad_cmd pulse, retired_count unchanged.
// - rst asserted during CAPTURE: no WRITE occurs, target set unchanged after sweep, retired_count=0.

Source files
------------

// File: rtl/cache_set_sequencer_pkg.sv
// Shared types for the L1 set sequencer: trace command, cache line, FSM states and helpers.
package cache_set_sequencer_pkg;
   localparam int DATA_WAYS  = 8;
   localparam int INSTR_WAYS = 4;
   localparam int TAG_W      = 12;
   localparam int SET_W      = 14;
   localparam int OFFSET_W   = 6;
   localparam int LRU_W      = 3;

   localparam logic [3:0] CMD_IFETCH = 4'd2;
   localparam logic [3:0] CMD_LAST   = 4'd4;
   localparam logic [3:0] CMD_CLEAR  = 4'd8;
   localparam logic [3:0] CMD_PRINT  = 4'd9;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [SET_W-1:0]    set_index;
      logic [OFFSET_W-1:0] offset;
   } address_t;

   typedef struct packed {
      logic [3:0] n;
      address_t   address;
   } command_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [1:0]       MESI_bits;
      logic [LRU_W-1:0] LRU;
   } cache_line_t;

   typedef enum logic [2:0] {
      SWEEP, IDLE, FETCH, PRESENT, CAPTURE, WRITE
   } seq_state_t;

   // Invalid line whose LRU rank equals its way number.
   function automatic cache_line_t init_line(input int way);
      cache_line_t l;
      l = '0;
      l.LRU = LRU_W'(way);
      return l;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/cache_set_sequencer_if.sv
// Command handshake plus processor-facing set bus of the sequencer.
interface cache_set_sequencer_if;
   import cache_set_sequencer_pkg::*;

   logic                             cmd_valid;
   command_t                         cmd;
   logic                             cmd_ready;
   command_t                         instruction;
   logic                             read_enable;
   cache_line_t [DATA_WAYS-1:0]      current_line_d;
   cache_line_t [INSTR_WAYS-1:0]     current_line_i;
   cache_line_t [DATA_WAYS-1:0]      return_line_d;
   cache_line_t [INSTR_WAYS-1:0]     return_line_i;
   logic                             retire;
   logic                             print_req;
   logic                             bad_cmd;
   logic [31:0]                      retired_count;

   modport master (
      output cmd_valid, cmd, return_line_d, return_line_i,
      input  cmd_ready, instruction, read_enable, current_line_d, current_line_i,
             retire, print_req, bad_cmd, retired_count
   );

   modport slave (
      input  cmd_valid, cmd, return_line_d, return_line_i,
      output cmd_ready, instruction, read_enable, current_line_d, current_line_i,
             retire, print_req, bad_cmd, retired_count
   );
endinterface

// File: rtl/cache_set_sequencer_array.sv
// One cache tag/state array: a whole set per word, one sync write port, registered read port.
module cache_set_array
   import cache_set_sequencer_pkg::*;
#(
   parameter int SETS = 16384,
   parameter int WAYS = 8,
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [IDX_W-1:0]        waddr,
   input  cache_line_t [WAYS-1:0]  wdata,
   input  logic                    re,
   input  logic [IDX_W-1:0]        raddr,
   output cache_line_t [WAYS-1:0]  rdata
);
   cache_line_t [WAYS-1:0] mem [SETS];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Read register holds its value between reads so the set stays stable downstream.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else if (re)
         rdata <= mem[raddr];
   end
endmodule

// File: rtl/cache_set_sequencer.sv
// Sequences trace commands through fetch/present/capture/write of one L1 set, plus clear sweep and print.
module cache_set_sequencer
   import cache_set_sequencer_pkg::*;
#(
   parameter int SETS = 16384
) (
   input  logic                  clk,
   input  logic                  rst,
   cache_set_sequencer_if.slave  bus
);
   localparam int IDX_W = $clog2(SETS);

   seq_state_t                   state_reg;
   logic [IDX_W-1:0]             sweep_idx_reg;
   logic                         sweep_retire_reg;
   command_t                     instruction_reg;
   cache_line_t [DATA_WAYS-1:0]  capture_d_reg;
   cache_line_t [INSTR_WAYS-1:0] capture_i_reg;
   logic                         read_enable_reg;
   logic                         retire_reg;
   logic                         print_req_reg;
   logic                         bad_cmd_reg;
   logic [31:0]                  retired_count_reg;

   cache_line_t [DATA_WAYS-1:0]  init_d, wdata_d, rdata_d;
   cache_line_t [INSTR_WAYS-1:0] init_i, wdata_i, rdata_i;
   logic [IDX_W-1:0]             set_idx, waddr;
   logic                         is_sweep, is_write, wr_d, wr_i, cmd_ready;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WAYS; gi++) begin : g_init
         assign init_d[gi] = init_line(gi);
         if (gi < INSTR_WAYS) begin : g_instr
            assign init_i[gi] = init_line(gi);
         end
      end
   endgenerate

   // Print occupies the single cycle after its accept, so readiness drops then too.
   assign cmd_ready = (state_reg == IDLE) && !print_req_reg;
   assign set_idx   = instruction_reg.address.set_index[IDX_W-1:0];
   assign is_sweep  = (state_reg == SWEEP);
   assign is_write  = (state_reg == WRITE);
   assign waddr     = is_sweep ? sweep_idx_reg : set_idx;
   assign wdata_d   = is_sweep ? init_d : capture_d_reg;
   assign wdata_i   = is_sweep ? init_i : capture_i_reg;
   assign wr_d      = !rst && (is_sweep || (is_write && instruction_reg.n != CMD_IFETCH));
   assign wr_i      = !rst && (is_sweep || (is_write && instruction_reg.n == CMD_IFETCH));

   cache_set_array #(.SETS(SETS), .WAYS(DATA_WAYS)) u_data (
      .clk(clk), .rst(rst), .we(wr_d), .waddr(waddr), .wdata(wdata_d),
      .re(state_reg == FETCH), .raddr(set_idx), .rdata(rdata_d)
   );

   cache_set_array #(.SETS(SETS), .WAYS(INSTR_WAYS)) u_instr (
      .clk(clk), .rst(rst), .we(wr_i), .waddr(waddr), .wdata(wdata_i),
      .re(state_reg == FETCH), .raddr(set_idx), .rdata(rdata_i)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= SWEEP;
         sweep_idx_reg     <= '0;
         sweep_retire_reg  <= 1'b0;
         instruction_reg   <= '0;
         capture_d_reg     <= '0;
         capture_i_reg     <= '0;
         read_enable_reg   <= 1'b0;
         retire_reg        <= 1'b0;
         print_req_reg     <= 1'b0;
         bad_cmd_reg       <= 1'b0;
         retired_count_reg <= '0;
      end else begin
         read_enable_reg <= 1'b0;
         retire_reg      <= 1'b0;
         print_req_reg   <= 1'b0;
         bad_cmd_reg     <= 1'b0;
         case (state_reg)
            SWEEP: begin
               sweep_idx_reg <= sweep_idx_reg + 1'b1;
               // A clear command retires during the final sweep cycle; the reset sweep never does.
               if (sweep_retire_reg && sweep_idx_reg == IDX_W'(SETS - 2)) begin
                  retire_reg        <= 1'b1;
                  retired_count_reg <= sat_inc(retired_count_reg);
               end
               if (sweep_idx_reg == IDX_W'(SETS - 1)) begin
                  state_reg        <= IDLE;
                  sweep_idx_reg    <= '0;
                  sweep_retire_reg <= 1'b0;
               end
            end
            IDLE: begin
               if (bus.cmd_valid && cmd_ready) begin
                  if (bus.cmd.n <= CMD_LAST) begin
                     instruction_reg <= bus.cmd;
                     state_reg       <= FETCH;
                  end else if (bus.cmd.n == CMD_CLEAR) begin
                     instruction_reg  <= bus.cmd;
                     state_reg        <= SWEEP;
                     sweep_idx_reg    <= '0;
                     sweep_retire_reg <= 1'b1;
                  end else if (bus.cmd.n == CMD_PRINT) begin
                     print_req_reg     <= 1'b1;
                     retire_reg        <= 1'b1;
                     retired_count_reg <= sat_inc(retired_count_reg);
                  end else begin
                     bad_cmd_reg <= 1'b1;
                  end
               end
            end
            FETCH: begin
               state_reg       <= PRESENT;
               read_enable_reg <= 1'b1;
            end
            PRESENT: state_reg <= CAPTURE;
            CAPTURE: begin
               capture_d_reg     <= bus.return_line_d;
               capture_i_reg     <= bus.return_line_i;
               state_reg         <= WRITE;
               retire_reg        <= 1'b1;
               retired_count_reg <= sat_inc(retired_count_reg);
            end
            WRITE:   state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready      = cmd_ready;
   assign bus.instruction    = instruction_reg;
   assign bus.read_enable    = read_enable_reg;
   assign bus.current_line_d = rdata_d;
   assign bus.current_line_i = rdata_i;
   assign bus.retire         = retire_reg;
   assign bus.print_req      = print_req_reg;
   assign bus.bad_cmd        = bad_cmd_reg;
   assign bus.retired_count  = retired_count_reg;
endmodule
